data_sram_bridge: RTL and testbench

DATA_SRAM_BRIDGE -- requirements
Module: data_sram_bridge

---
 rtl/data_sram_bridge.sv | 149 ++++++++++++++
 tb/tb_data_sram_bridge.sv | 413 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_sram_bridge.sv
// Data-side bridge from the MEM stage to an SRAM-like request/response bus.
// Issues at most one transaction at a time. It holds the request until the bus
// accepts it, then waits for the response. After the response it parks in a
// hold state while the rest of the pipeline is stalled, so the same access is
// never issued twice.
module data_sram_bridge (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_en,
  input  logic        cpu_we,
  input  logic [1:0]  cpu_size,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic        cpu_longest_stall,
  output logic [31:0] cpu_rdata,
  output logic        cpu_stallreq,
  output logic        data_req,
  output logic        data_wr,
  output logic [1:0]  data_size,
  output logic [31:0] data_addr,
  output logic [31:0] data_wdata,
  input  logic        data_addr_ok,
  input  logic        data_data_ok,
  input  logic [31:0] data_rdata
);

  typedef enum logic [1:0] {
    StIdle     = 2'd0,
    StWaitAddr = 2'd1,
    StWaitData = 2'd2,
    StHold     = 2'd3
  } state_e;

  state_e      state_q, state_d;

  // Request register: a copy of the access as it was first presented, so the
  // bus sees stable fields even if the MEM stage changes or is flushed.
  logic        req_we_q, req_we_d;
  logic [1:0]  req_size_q, req_size_d;
  logic [31:0] req_addr_q, req_addr_d;
  logic [31:0] req_wdata_q, req_wdata_d;

  // Last load data, returned to the MEM stage once the bus has moved on.
  logic [31:0] rdata_q, rdata_d;

  // Outputs before reset gating.
  logic        req_raw;
  logic        stall_raw;
  logic [31:0] rdata_raw;

  // State, request register and load data register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      req_we_q    <= 1'b0;
      req_size_q  <= 2'd0;
      req_addr_q  <= 32'd0;
      req_wdata_q <= 32'd0;
      rdata_q     <= 32'd0;
    end else begin
      state_q     <= state_d;
      req_we_q    <= req_we_d;
      req_size_q  <= req_size_d;
      req_addr_q  <= req_addr_d;
      req_wdata_q <= req_wdata_d;
      rdata_q     <= rdata_d;
    end
  end

  // Next-state logic, bus fields, stall request and load data selection.
  always_comb begin
    state_d     = state_q;
    req_we_d    = req_we_q;
    req_size_d  = req_size_q;
    req_addr_d  = req_addr_q;
    req_wdata_d = req_wdata_q;
    rdata_d     = rdata_q;

    req_raw     = 1'b0;
    stall_raw   = 1'b0;
    rdata_raw   = rdata_q;

    data_wr     = req_we_q;
    data_size   = req_size_q;
    data_addr   = req_addr_q;
    data_wdata  = req_wdata_q;

    unique case (state_q)
      StIdle: begin
        if (cpu_en) begin
          // Present the access straight from the MEM stage to save a cycle,
          // and keep a copy in case the bus does not accept it right away.
          req_raw     = 1'b1;
          stall_raw   = 1'b1;
          data_wr     = cpu_we;
          data_size   = cpu_size;
          data_addr   = cpu_addr;
          data_wdata  = cpu_wdata;
          req_we_d    = cpu_we;
          req_size_d  = cpu_size;
          req_addr_d  = cpu_addr;
          req_wdata_d = cpu_wdata;
          state_d     = data_addr_ok ? StWaitData : StWaitAddr;
        end
      end

      StWaitAddr: begin
        // Once raised, the request stays up until accepted, even if flushed.
        req_raw   = 1'b1;
        stall_raw = 1'b1;
        if (data_addr_ok) begin
          state_d = StWaitData;
        end
      end

      StWaitData: begin
        if (data_data_ok) begin
          rdata_raw = data_rdata;
          if (!req_we_q) begin
            rdata_d = data_rdata;
          end
          // The pipeline cannot consume the result yet: park rather than
          // return to idle, where the still-valid access would re-issue.
          state_d = cpu_longest_stall ? StHold : StIdle;
        end else begin
          stall_raw = 1'b1;
        end
      end

      StHold: begin
        if (!cpu_longest_stall) begin
          state_d = StIdle;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Handshake outputs are forced quiet while reset is asserted.
  always_comb begin
    data_req     = req_raw & ~rst;
    cpu_stallreq = stall_raw & ~rst;
    cpu_rdata    = rst ? 32'd0 : rdata_raw;
  end

endmodule

// File: tb/tb_data_sram_bridge.sv
module tb_data_sram_bridge;

  logic        clk;
  logic        rst;
  logic        cpu_en;
  logic        cpu_we;
  logic [1:0]  cpu_size;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic        cpu_longest_stall;
  logic [31:0] cpu_rdata;
  logic        cpu_stallreq;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;

  int n_cmp;
  int n_fail;

  data_sram_bridge dut (
    .clk               (clk),
    .rst               (rst),
    .cpu_en            (cpu_en),
    .cpu_we            (cpu_we),
    .cpu_size          (cpu_size),
    .cpu_addr          (cpu_addr),
    .cpu_wdata         (cpu_wdata),
    .cpu_longest_stall (cpu_longest_stall),
    .cpu_rdata         (cpu_rdata),
    .cpu_stallreq      (cpu_stallreq),
    .data_req          (data_req),
    .data_wr           (data_wr),
    .data_size         (data_size),
    .data_addr         (data_addr),
    .data_wdata        (data_wdata),
    .data_addr_ok      (data_addr_ok),
    .data_data_ok      (data_data_ok),
    .data_rdata        (data_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    cpu_en            = 1'b0;
    cpu_we            = 1'b0;
    cpu_size          = 2'd2;
    cpu_addr          = 32'd0;
    cpu_wdata         = 32'd0;
    cpu_longest_stall = 1'b0;
    data_addr_ok      = 1'b0;
    data_data_ok      = 1'b0;
    data_rdata        = 32'd0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_inputs();
    cpu_en       = 1'b1;
    cpu_addr     = 32'h0000_1000;
    data_addr_ok = 1'b1;
    data_rdata   = 32'hFFFF_FFFF;
    tick();
    #2;
    n_cmp++; if (data_req !== 1'b0) begin n_fail++;
      $display("FAIL rst_req got %b want 0", data_req); end
    n_cmp++; if (cpu_stallreq !== 1'b0) begin n_fail++;
      $display("FAIL rst_stall got %b want 0", cpu_stallreq); end
    n_cmp++; if (cpu_rdata !== 32'd0) begin n_fail++;
      $display("FAIL rst_rdata got %h want 0", cpu_rdata); end
    tick();
    rst = 1'b0;
    clear_inputs();
    #2;
    n_cmp++; if (data_req !== 1'b0 || cpu_stallreq !== 1'b0) begin n_fail++;
      $display("FAIL rst_idle got req=%b stall=%b want 0/0", data_req, cpu_stallreq); end
    n_cmp++; if (cpu_rdata !== 32'd0) begin n_fail++;
      $display("FAIL rst_idle_rdata got %h want 0", cpu_rdata); end
    tick();
  endtask

  task automatic test_zero_wait_load();
    clear_inputs();
    cpu_en       = 1'b1;
    cpu_addr     = 32'h8000_0010;
    data_addr_ok = 1'b1;
    #2;
    n_cmp++; if (data_req !== 1'b1 || cpu_stallreq !== 1'b1) begin n_fail++;
      $display("FAIL zw_issue got req=%b stall=%b want 1/1", data_req, cpu_stallreq); end
    n_cmp++; if (data_addr !== 32'h8000_0010 || data_wr !== 1'b0) begin n_fail++;
      $display("FAIL zw_fields got addr=%h wr=%b want 80000010/0", data_addr, data_wr); end
    tick();
    data_addr_ok = 1'b0;
    data_data_ok = 1'b1;
    data_rdata   = 32'hDEAD_BEEF;
    #2;
    n_cmp++; if (data_req !== 1'b0 || cpu_stallreq !== 1'b0) begin n_fail++;
      $display("FAIL zw_data got req=%b stall=%b want 0/0", data_req, cpu_stallreq); end
    n_cmp++; if (cpu_rdata !== 32'hDEAD_BEEF) begin n_fail++;
      $display("FAIL zw_rdata got %h want deadbeef", cpu_rdata); end
    tick();
    clear_inputs();
    #2;
    n_cmp++; if (data_req !== 1'b0 || cpu_rdata !== 32'hDEAD_BEEF) begin n_fail++;
      $display("FAIL zw_after got req=%b rdata=%h want 0/deadbeef", data_req, cpu_rdata); end
    tick();
  endtask

  task automatic test_addr_backpressure();
    int req_cycles;
    req_cycles = 0;
    clear_inputs();
    cpu_en   = 1'b1;
    cpu_addr = 32'h0000_2000;
    for (int c = 0; c < 4; c++) begin
      if (c == 1) cpu_addr = 32'h0000_2F00;
      data_addr_ok = (c == 3);
      #2;
      if (data_req === 1'b1) req_cycles++;
      n_cmp++; if (data_addr !== 32'h0000_2000) begin n_fail++;
        $display("FAIL bp_addr cycle %0d got %h want 00002000", c, data_addr); end
      n_cmp++; if (cpu_stallreq !== 1'b1) begin n_fail++;
        $display("FAIL bp_stall cycle %0d got %b want 1", c, cpu_stallreq); end
      tick();
    end
    data_addr_ok = 1'b0;
    data_data_ok = 1'b1;
    data_rdata   = 32'hA5A5_0001;
    #2;
    if (data_req === 1'b1) req_cycles++;
    n_cmp++; if (cpu_stallreq !== 1'b0 || cpu_rdata !== 32'hA5A5_0001) begin n_fail++;
      $display("FAIL bp_data got stall=%b rdata=%h want 0/a5a50001", cpu_stallreq, cpu_rdata);
    end
    n_cmp++; if (req_cycles != 4) begin n_fail++;
      $display("FAIL bp_req_cycles got %0d want 4", req_cycles); end
    tick();
    clear_inputs();
    tick();
  endtask

  task automatic test_stall_hold();
    clear_inputs();
    cpu_en       = 1'b1;
    cpu_addr     = 32'h0000_0100;
    data_addr_ok = 1'b1;
    tick();
    data_addr_ok      = 1'b0;
    data_data_ok      = 1'b1;
    data_rdata        = 32'h1234_5678;
    cpu_longest_stall = 1'b1;
    #2;
    n_cmp++; if (cpu_stallreq !== 1'b0 || cpu_rdata !== 32'h1234_5678) begin n_fail++;
      $display("FAIL hold_data got stall=%b rdata=%h want 0/12345678", cpu_stallreq, cpu_rdata);
    end
    tick();
    // Stray handshakes and new bus data must be ignored while parked.
    for (int c = 0; c < 5; c++) begin
      cpu_longest_stall = (c < 4);
      data_addr_ok      = c[0];
      data_data_ok      = ~c[0];
      data_rdata        = 32'hBAD0_0000 + c;
      #2;
      n_cmp++; if (data_req !== 1'b0 || cpu_stallreq !== 1'b0) begin n_fail++;
        $display("FAIL hold_quiet cycle %0d got req=%b stall=%b want 0/0", c, data_req,
                 cpu_stallreq); end
      n_cmp++; if (cpu_rdata !== 32'h1234_5678) begin n_fail++;
        $display("FAIL hold_rdata cycle %0d got %h want 12345678", c, cpu_rdata); end
      tick();
    end
    clear_inputs();
    #2;
    n_cmp++; if (data_req !== 1'b0 || cpu_rdata !== 32'h1234_5678) begin n_fail++;
      $display("FAIL hold_exit got req=%b rdata=%h want 0/12345678", data_req, cpu_rdata); end
    tick();
    cpu_en   = 1'b1;
    cpu_addr = 32'h0000_0200;
    #2;
    n_cmp++; if (data_req !== 1'b1 || data_addr !== 32'h0000_0200) begin n_fail++;
      $display("FAIL hold_reissue got req=%b addr=%h want 1/00000200", data_req, data_addr); end
    tick();
    data_addr_ok = 1'b1;
    tick();
    data_addr_ok = 1'b0;
    data_data_ok = 1'b1;
    data_rdata   = 32'hCAFE_F00D;
    tick();
    clear_inputs();
    tick();
  endtask

  task automatic test_flush();
    clear_inputs();
    cpu_en       = 1'b1;
    cpu_addr     = 32'h0000_0300;
    data_addr_ok = 1'b1;
    tick();
    clear_inputs();
    for (int c = 0; c < 2; c++) begin
      data_addr_ok = (c == 1);
      #2;
      n_cmp++; if (data_req !== 1'b0 || cpu_stallreq !== 1'b1) begin n_fail++;
        $display("FAIL flush_wait cycle %0d got req=%b stall=%b want 0/1", c, data_req,
                 cpu_stallreq); end
      tick();
    end
    data_addr_ok = 1'b0;
    data_data_ok = 1'b1;
    data_rdata   = 32'h0BAD_F00D;
    #2;
    n_cmp++; if (data_req !== 1'b0 || cpu_stallreq !== 1'b0) begin n_fail++;
      $display("FAIL flush_done got req=%b stall=%b want 0/0", data_req, cpu_stallreq); end
    tick();
    clear_inputs();
    #2;
    n_cmp++; if (data_req !== 1'b0 || cpu_stallreq !== 1'b0) begin n_fail++;
      $display("FAIL flush_idle got req=%b stall=%b want 0/0", data_req, cpu_stallreq); end
    tick();
    cpu_en       = 1'b1;
    cpu_addr     = 32'h0000_0304;
    data_addr_ok = 1'b1;
    #2;
    n_cmp++; if (data_req !== 1'b1 || data_addr !== 32'h0000_0304) begin n_fail++;
      $display("FAIL flush_next got req=%b addr=%h want 1/00000304", data_req, data_addr); end
    tick();
    data_addr_ok = 1'b0;
    data_data_ok = 1'b1;
    data_rdata   = 32'h1111_2222;
    tick();
    clear_inputs();
    #2;
    n_cmp++; if (cpu_rdata !== 32'h1111_2222) begin n_fail++;
      $display("FAIL flush_next_rdata got %h want 11112222", cpu_rdata); end
    tick();
  endtask

  task automatic test_store();
    clear_inputs();
    cpu_en       = 1'b1;
    cpu_we       = 1'b1;
    cpu_size     = 2'd0;
    cpu_addr     = 32'h0000_0003;
    cpu_wdata    = 32'hAA00_0000;
    data_addr_ok = 1'b1;
    #2;
    n_cmp++; if (data_req !== 1'b1 || data_wr !== 1'b1 || data_size !== 2'd0) begin n_fail++;
      $display("FAIL st_ctl got req=%b wr=%b size=%0d want 1/1/0", data_req, data_wr,
               data_size); end
    n_cmp++; if (data_addr !== 32'h3 || data_wdata !== 32'hAA00_0000) begin n_fail++;
      $display("FAIL st_fields got addr=%h wdata=%h want 00000003/aa000000", data_addr,
               data_wdata); end
    tick();
    data_addr_ok = 1'b0;
    #2;
    n_cmp++; if (data_req !== 1'b0 || cpu_stallreq !== 1'b1) begin n_fail++;
      $display("FAIL st_wait got req=%b stall=%b want 0/1", data_req, cpu_stallreq); end
    tick();
    data_data_ok = 1'b1;
    data_rdata   = 32'h5555_5555;
    #2;
    n_cmp++; if (cpu_stallreq !== 1'b0) begin n_fail++;
      $display("FAIL st_ack got stall=%b want 0", cpu_stallreq); end
    tick();
    clear_inputs();
    #2;
    n_cmp++; if (cpu_rdata !== 32'h1111_2222) begin n_fail++;
      $display("FAIL st_rdata_kept got %h want 11112222", cpu_rdata); end
    tick();
  endtask

  task automatic test_reset_mid();
    clear_inputs();
    cpu_en   = 1'b1;
    cpu_addr = 32'h0000_0400;
    #2;
    n_cmp++; if (data_req !== 1'b1) begin n_fail++;
      $display("FAIL rm_issue got %b want 1", data_req); end
    tick();
    rst = 1'b1;
    #2;
    n_cmp++; if (data_req !== 1'b0 || cpu_stallreq !== 1'b0 || cpu_rdata !== 32'd0) begin
      n_fail++;
      $display("FAIL rm_during got req=%b stall=%b rdata=%h want 0/0/0", data_req,
               cpu_stallreq, cpu_rdata); end
    tick();
    rst = 1'b0;
    clear_inputs();
    data_addr_ok = 1'b1;
    #2;
    n_cmp++; if (data_req !== 1'b0 || cpu_stallreq !== 1'b0 || cpu_rdata !== 32'd0) begin
      n_fail++;
      $display("FAIL rm_after got req=%b stall=%b rdata=%h want 0/0/0", data_req,
               cpu_stallreq, cpu_rdata); end
    tick();
    cpu_en       = 1'b1;
    cpu_addr     = 32'h0000_0500;
    data_addr_ok = 1'b0;
    #2;
    n_cmp++; if (data_req !== 1'b1 || data_addr !== 32'h0000_0500) begin n_fail++;
      $display("FAIL rm_new got req=%b addr=%h want 1/00000500", data_req, data_addr); end
    tick();
    cpu_en       = 1'b0;
    cpu_addr     = 32'h0000_0600;
    data_addr_ok = 1'b1;
    #2;
    n_cmp++; if (data_req !== 1'b1 || data_addr !== 32'h0000_0500) begin n_fail++;
      $display("FAIL rm_held got req=%b addr=%h want 1/00000500", data_req, data_addr); end
    tick();
    data_addr_ok = 1'b0;
    data_data_ok = 1'b1;
    data_rdata   = 32'h0000_0077;
    tick();
    clear_inputs();
    tick();
  endtask

  // Random traffic against a transaction-level model: a transaction is opened
  // by a valid access while nothing is pending, accepted by the first addr_ok,
  // closed by the first data_ok after acceptance, and then the bridge stays
  // silent for as long as the pipeline-wide stall persists.
  task automatic test_random();
    bit          busy, accepted, parked;
    bit          m_we;
    logic [1:0]  m_size;
    logic [31:0] m_addr, m_wdata, m_rdata;
    bit          fresh, exp_req, exp_stall;
    logic [31:0] exp_rdata;
    logic        exp_wr;
    logic [1:0]  exp_size;
    logic [31:0] exp_addr, exp_wdata;
    busy = 0; accepted = 0; parked = 0;
    m_we = 0; m_size = 0; m_addr = 0; m_wdata = 0; m_rdata = 0;
    rst = 1'b1;
    clear_inputs();
    tick();
    rst = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      cpu_en            = ($urandom_range(3) != 0);
      cpu_we            = $urandom_range(1);
      cpu_size          = 2'($urandom_range(2));
      cpu_addr          = $urandom;
      cpu_wdata         = $urandom;
      cpu_longest_stall = ($urandom_range(3) == 0);
      data_addr_ok      = $urandom_range(1);
      data_data_ok      = $urandom_range(1);
      data_rdata        = $urandom;
      #2;
      fresh     = !busy && !parked && cpu_en;
      exp_req   = fresh || (busy && !accepted);
      exp_stall = fresh || (busy && !accepted) || (busy && accepted && !data_data_ok);
      exp_rdata = (busy && accepted && data_data_ok) ? data_rdata : m_rdata;
      exp_wr    = fresh ? cpu_we : m_we;
      exp_size  = fresh ? cpu_size : m_size;
      exp_addr  = fresh ? cpu_addr : m_addr;
      exp_wdata = fresh ? cpu_wdata : m_wdata;
      n_cmp++; if (data_req !== exp_req || cpu_stallreq !== exp_stall) begin n_fail++;
        $display("FAIL rnd_ctl cycle %0d got req=%b stall=%b want %b/%b", cyc, data_req,
                 cpu_stallreq, exp_req, exp_stall); end
      n_cmp++; if (cpu_rdata !== exp_rdata) begin n_fail++;
        $display("FAIL rnd_rdata cycle %0d got %h want %h", cyc, cpu_rdata, exp_rdata); end
      if (exp_req) begin
        n_cmp++;
        if (data_wr !== exp_wr || data_size !== exp_size || data_addr !== exp_addr ||
            data_wdata !== exp_wdata) begin
          n_fail++;
          $display("FAIL rnd_bus cycle %0d got %b/%0d/%h/%h want %b/%0d/%h/%h", cyc, data_wr,
                   data_size, data_addr, data_wdata, exp_wr, exp_size, exp_addr, exp_wdata);
        end
      end
      if (fresh) begin
        m_we = cpu_we; m_size = cpu_size; m_addr = cpu_addr; m_wdata = cpu_wdata;
        busy = 1; accepted = data_addr_ok;
      end else if (busy && !accepted) begin
        accepted = data_addr_ok;
      end else if (busy && data_data_ok) begin
        if (!m_we) m_rdata = data_rdata;
        busy = 0; accepted = 0; parked = cpu_longest_stall;
      end else if (parked) begin
        parked = cpu_longest_stall;
      end
      tick();
    end
    clear_inputs();
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    rst    = 1'b1;
    clear_inputs();
    test_reset();
    test_zero_wait_load();
    test_addr_backpressure();
    test_stall_hold();
    test_flush();
    test_store();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
